// File: rtl/uart_io_port_if.sv
// Microcode-side register bus of the UART peripheral: strobes, selects and
// the 8-bit data paths to and from the MM/IO read multiplexer.
interface uart_io_port_if;
  logic       rd;
  logic       wr;
  logic       s_mmio;
  logic       s_io;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output rd, wr, s_mmio, s_io, data_in, input data_out);
  modport slave  (input rd, wr, s_mmio, s_io, data_in, output data_out);
endinterface

// File: rtl/uart_io_port.sv
// Memory-mapped UART: TX shifter with holding register, RX deserializer,
// small RX FIFO and sticky error flags, accessed through edge-qualified
// microcode strobes.
//
// state | meaning (both FSMs)
// IDLE  | line idle; TX ready for a load / RX waiting for a falling edge
// START | start bit (TX driving 0 / RX waiting for mid-bit check)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit
module uart_io_port #(
  parameter int clk_freq = 50000000,
  parameter int baud     = 9600,
  parameter int RX_AW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  output logic           tx,
  uart_io_port_if.slave  bus
);
  localparam int DIV   = clk_freq / baud;
  localparam int CW    = $clog2(DIV);
  localparam int DEPTH = 2 ** RX_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------- strobe qualification ----------------
  logic rd_lvl, wr_lvl, rd_q, wr_q, rd_ev, wr_ev;
  assign rd_lvl = bus.rd & bus.s_mmio;
  assign wr_lvl = bus.wr & bus.s_mmio;
  assign rd_ev  = rd_lvl & ~rd_q;
  assign wr_ev  = wr_lvl & ~wr_q;

  // remember previous strobe levels so a held strobe acts once
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd_lvl;
      wr_q <= wr_lvl;
    end
  end

  // ---------------- TX ----------------
  state_t          tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [7:0]      tx_shift, tx_shift_n;
  logic [2:0]      tx_bit, tx_bit_n;
  logic            tx_ready, tx_load;

  assign tx_ready = (tx_state == IDLE);
  assign tx_load  = wr_ev & ~bus.s_io & tx_ready;

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
    end
  end

  // TX next state and line level; each bit is a DIV-cycle down-count
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    tx         = 1'b1;
    case (tx_state)
      IDLE: begin
        if (tx_load) begin
          tx_state_n = START;
          tx_cnt_n   = CW'(DIV - 1);
          tx_shift_n = bus.data_in;
        end
      end
      START: begin
        tx = 1'b0;
        if (tx_cnt == '0) begin
          tx_state_n = DATA;
          tx_cnt_n   = CW'(DIV - 1);
          tx_bit_n   = '0;
        end else tx_cnt_n = tx_cnt - CW'(1);
      end
      DATA: begin
        tx = tx_shift[0];
        if (tx_cnt == '0) begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_cnt_n   = CW'(DIV - 1);
          if (tx_bit == 3'd7) tx_state_n = STOP;
          else tx_bit_n = tx_bit + 3'd1;
        end else tx_cnt_n = tx_cnt - CW'(1);
      end
      STOP: begin
        if (tx_cnt == '0) tx_state_n = IDLE;
        else tx_cnt_n = tx_cnt - CW'(1);
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------- RX ----------------
  logic rx_s1, rx_s2, rx_d;

  // two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  state_t          rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic            rx_push, frame_set;

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_shift <= rx_shift_n;
      rx_bit   <= rx_bit_n;
    end
  end

  // RX next state; start bit rechecked at half a bit to reject glitches
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_shift_n = rx_shift;
    rx_bit_n   = rx_bit;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    case (rx_state)
      IDLE: begin
        if (rx_d & ~rx_s2) begin
          rx_state_n = START;
          rx_cnt_n   = CW'(DIV / 2 - 1);
        end
      end
      START: begin
        if (rx_cnt == '0) begin
          if (rx_s2) rx_state_n = IDLE;
          else begin
            rx_state_n = DATA;
            rx_cnt_n   = CW'(DIV - 1);
            rx_bit_n   = '0;
          end
        end else rx_cnt_n = rx_cnt - CW'(1);
      end
      DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_cnt_n   = CW'(DIV - 1);
          if (rx_bit == 3'd7) rx_state_n = STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt - CW'(1);
      end
      STOP: begin
        if (rx_cnt == '0) begin
          rx_state_n = IDLE;
          if (rx_s2) rx_push = 1'b1;
          else frame_set = 1'b1;
        end else rx_cnt_n = rx_cnt - CW'(1);
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // ---------------- RX FIFO and flags ----------------
  logic [7:0]       mem [DEPTH];
  logic [RX_AW-1:0] wptr, rptr;
  logic [RX_AW:0]   count;
  logic             full, empty, pop, push_ok, overrun_set, err_clr;
  logic             overrun, frame_err;

  assign full        = (count == (RX_AW + 1)'(DEPTH));
  assign empty       = (count == '0);
  assign pop         = rd_ev & ~bus.s_io & ~empty;
  assign push_ok     = rx_push & (~full | pop);
  assign overrun_set = rx_push & full & ~pop;
  assign err_clr     = rd_ev & bus.s_io;

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= rx_shift;
  end

  // FIFO pointers, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + RX_AW'(1);
      if (pop) rptr <= rptr + RX_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (RX_AW + 1)'(1);
        2'b01:   count <= count - (RX_AW + 1)'(1);
        default: count <= count;
      endcase
      overrun   <= overrun_set | (overrun & ~err_clr);
      frame_err <= frame_set | (frame_err & ~err_clr);
    end
  end

  // read mux: FIFO head (zero when empty) or status
  always_comb begin
    bus.data_out = 8'h00;
    if (bus.s_io) bus.data_out = {4'b0, frame_err, overrun, ~empty, tx_ready};
    else if (!empty) bus.data_out = mem[rptr];
  end
endmodule

// File: tb/tb_uart_io_port.sv
// Directed bench for uart_io_port at DIV=16 (1600 Hz clock, 100 baud).
module tb_uart_io_port;
  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic tx;
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_io_port_if bus ();

  uart_io_port #(.clk_freq(1600), .baud(100), .RX_AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .tx  (tx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // look at a register without generating a read event
  task automatic peek(input logic sio, output logic [7:0] v);
    logic old_sio, old_rd;
    old_sio = bus.s_io;
    old_rd  = bus.rd;
    bus.rd   = 1'b0;
    bus.s_io = sio;
    #1;
    v = bus.data_out;
    bus.s_io = old_sio;
    bus.rd   = old_rd;
    #1;
  endtask

  // full read access: capture data, then hold rd for n cycles
  task automatic reg_read(input logic sio, input int n, output logic [7:0] v);
    bus.s_mmio = 1'b1;
    bus.s_io   = sio;
    #1;
    v = bus.data_out;
    bus.rd = 1'b1;
    tick(n);
    bus.rd = 1'b0;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx = frame[b];
      tick(16);
    end
    rx = 1'b1;
  endtask

  // write a byte with wr held 3 cycles and check the whole frame on tx
  task automatic tx_frame(input logic [7:0] d, input bit inject, input string tag);
    logic [7:0] v;
    logic       exp_b;
    int         b;
    bus.s_mmio  = 1'b1;
    bus.s_io    = 1'b0;
    bus.data_in = d;
    bus.wr      = 1'b1;
    tick(1);
    for (int c = 0; c <= 160; c++) begin
      if (c == 2) bus.wr = 1'b0;
      if (inject && c == 40) begin
        bus.data_in = ~d;
        bus.wr = 1'b1;
      end
      if (inject && c == 42) bus.wr = 1'b0;
      if (c % 16 == 8) begin
        b = c / 16;
        if (b == 0) exp_b = 1'b0;
        else if (b == 9) exp_b = 1'b1;
        else exp_b = d[b-1];
        check($sformatf("%s_bit%0d", tag, b), {7'b0, tx}, {7'b0, exp_b});
      end
      if (c == 20 || c == 159) begin
        peek(1'b1, v);
        check($sformatf("%s_busy_c%0d", tag, c), v, 8'h00);
      end
      if (c == 160) begin
        peek(1'b1, v);
        check($sformatf("%s_ready", tag), v, 8'h01);
      end
      if (c < 160) tick(1);
    end
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    rx  = 1'b1;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.s_mmio = 1'b0;
    bus.s_io = 1'b0;
    bus.data_in = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(1);

    // reset state
    check("rst_tx", {7'b0, tx}, 8'h01);
    peek(1'b1, v); check("rst_status", v, 8'h01);
    peek(1'b0, v); check("rst_data", v, 8'h00);

    // TX frame with an ignored mid-frame write
    tx_frame(8'hA5, 1'b1, "txA5");
    tick(4);

    // RX single byte
    send_byte(8'h3C, 1'b1);
    tick(4);
    peek(1'b1, v); check("rx_status", v, 8'h03);
    peek(1'b0, v); check("rx_peek", v, 8'h3C);
    reg_read(1'b0, 4, v); check("rx_read", v, 8'h3C);
    peek(1'b1, v); check("rx_status_after", v, 8'h01);
    peek(1'b0, v); check("rx_data_after", v, 8'h00);

    // overrun: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    tick(4);
    peek(1'b1, v); check("ovr_status", v, 8'h07);
    for (int i = 1; i <= 4; i++) begin
      reg_read(1'b0, 2, v);
      check($sformatf("ovr_read%0d", i), v, 8'(i));
    end
    peek(1'b0, v); check("ovr_empty", v, 8'h00);
    reg_read(1'b1, 3, v); check("ovr_status_read", v, 8'h05);
    peek(1'b1, v); check("ovr_cleared", v, 8'h01);

    // framing error
    send_byte(8'h55, 1'b0);
    tick(20);
    peek(1'b1, v); check("ferr_status", v, 8'h09);
    peek(1'b0, v); check("ferr_data", v, 8'h00);
    reg_read(1'b1, 2, v); check("ferr_read", v, 8'h09);
    peek(1'b1, v); check("ferr_cleared", v, 8'h01);

    // glitch on rx
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(200);
    peek(1'b1, v); check("glitch_status", v, 8'h01);

    // reset in the middle of a transmission
    bus.s_mmio = 1'b1;
    bus.s_io = 1'b0;
    bus.data_in = 8'h5A;
    bus.wr = 1'b1;
    tick(3);
    bus.wr = 1'b0;
    tick(47);
    check("midtx_low", {7'b0, tx}, 8'h00);
    rst = 1'b1;
    tick(1);
    check("midrst_tx", {7'b0, tx}, 8'h01);
    peek(1'b1, v); check("midrst_status", v, 8'h01);
    rst = 1'b0;
    tick(2);
    tx_frame(8'hC3, 1'b0, "txC3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
